conv_32b_8b: RTL and testbench

CONV_32B_8B -- requirements
Module: conv_32b_8b

---
 rtl/conv_32b_8b.sv | 62 ++++++
 tb/tb_conv_32b_8b.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/conv_32b_8b.sv
// conv_32b_8b: serializes 32-bit words into a gapless MSB-first byte stream
// through a shifter plus a one-word pending buffer.
module conv_32b_8b (
   input  logic        clk_4f,
   input  logic        reset_L,
   input  logic [31:0] data_in,
   input  logic        valid_in,
   output logic        ready_out,
   output logic [7:0]  data_out,
   output logic        valid_out,
   output logic        idle_out
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;
   logic [0:0]  state;
   logic [1:0]  cnt;
   logic [31:0] shifter;
   logic [31:0] pending;
   logic        pending_full;
   logic        accept;
   assign ready_out = ~pending_full;
   assign accept    = valid_in & ~pending_full;
   assign valid_out = state == SEND;
   assign idle_out  = state == IDLE && !pending_full;
   assign data_out  = !valid_out  ? 8'h00 :
                      cnt == 2'd0 ? shifter[31:24] :
                      cnt == 2'd1 ? shifter[23:16] :
                      cnt == 2'd2 ? shifter[15:8]  : shifter[7:0];
   // At the last byte the pending word wins over a fresh input; otherwise a
   // fresh input bypasses pending so the stream stays gapless.
   always_ff @(posedge clk_4f) begin
      if (!reset_L) begin
         state        <= IDLE;
         cnt          <= 2'd0;
         pending_full <= 1'b0;
         shifter      <= 32'h0;
         pending      <= 32'h0;
      end else if (state == IDLE) begin
         if (accept) begin
            shifter <= data_in;
            cnt     <= 2'd0;
            state   <= SEND;
         end
      end else if (cnt != 2'd3) begin
         cnt <= cnt + 2'd1;
         if (accept) begin
            pending      <= data_in;
            pending_full <= 1'b1;
         end
      end else if (pending_full) begin
         shifter      <= pending;
         cnt          <= 2'd0;
         pending_full <= 1'b0;
      end else if (accept) begin
         shifter <= data_in;
         cnt     <= 2'd0;
      end else begin
         state <= IDLE;
         cnt   <= 2'd0;
      end
   end
endmodule

// File: tb/tb_conv_32b_8b.sv
// tb_conv_32b_8b: randomized and directed checks of conv_32b_8b against a
// byte-queue model of the output stream.
module tb_conv_32b_8b;
   logic        clk_4f = 1'b0;
   logic        reset_L = 1'b0;
   logic [31:0] data_in = 32'h0;
   logic        valid_in = 1'b0;
   logic        ready_out;
   logic [7:0]  data_out;
   logic        valid_out;
   logic        idle_out;
   int          checks = 0;
   int          fails = 0;
   logic [7:0]  q[$];
   logic [7:0]  got[$];
   bit          acc;
   logic [10:0] obs;
   conv_32b_8b dut (
      .clk_4f(clk_4f), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
      .ready_out(ready_out), .data_out(data_out), .valid_out(valid_out), .idle_out(idle_out)
   );
   always #5 clk_4f = ~clk_4f;
   assign obs = {valid_out, data_out, ready_out, idle_out};
   // The queue holds every byte still owed; more than 4 means a word waits behind the one being sent.
   function automatic logic [10:0] expv();
      logic [7:0] b = q.size() != 0 ? q[0] : 8'h00;
      return {q.size() != 0, b, q.size() <= 4, q.size() == 0};
   endfunction
   task automatic tick();
      @(posedge clk_4f);
      acc = 1'b0;
      if (!reset_L) q.delete();
      else begin
         acc = valid_in && q.size() <= 4;
         if (q.size() != 0) void'(q.pop_front());
         if (acc) for (int k = 3; k >= 0; k--) q.push_back(data_in[8*k +: 8]);
      end
      #1;
      if (valid_out) got.push_back(data_out);
   endtask
   task automatic test_reset();
      reset_L = 1'b0; valid_in = 1'b1; data_in = 32'h12345678;
      tick(); tick();
      checks++;
      if (obs !== 11'b0_00000000_1_1) begin fails++; $display("FAIL reset_state: got %h want %h", obs, 11'b0_00000000_1_1); end
      reset_L = 1'b1; valid_in = 1'b0;
      tick();
      checks++;
      if (obs !== 11'b0_00000000_1_1) begin fails++; $display("FAIL reset_drop: got %h want %h", obs, 11'b0_00000000_1_1); end
   endtask
   task automatic test_single();
      logic [7:0] e[$] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      bit ok;
      got.delete();
      valid_in = 1'b1; data_in = 32'hA1B2C3D4;
      for (int i = 0; i < 6; i++) begin
         tick();
         valid_in = 1'b0;
         checks++;
         if (obs !== expv()) begin fails++; $display("FAIL single cyc%0d: got %h want %h", i, obs, expv()); end
      end
      ok = got.size() == e.size();
      foreach (e[k]) if (k < got.size() && got[k] !== e[k]) ok = 0;
      checks++;
      if (!ok) begin fails++; $display("FAIL single_bytes: got %p want %p", got, e); end
      checks++;
      if (obs !== 11'b0_00000000_1_1) begin fails++; $display("FAIL single_end: got %h want %h", obs, 11'b0_00000000_1_1); end
   endtask
   task automatic test_stream();
      logic [31:0] w[2] = '{32'h11223344, 32'h55667788};
      logic [7:0] e[$] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      int idx = 0;
      bit ok;
      got.delete();
      for (int i = 0; i < 12; i++) begin
         valid_in = idx < 2; data_in = w[idx % 2];
         tick();
         if (acc) idx++;
         checks++;
         if (obs !== expv()) begin fails++; $display("FAIL stream cyc%0d: got %h want %h", i, obs, expv()); end
         if (i < 8) begin
            checks++;
            if (valid_out !== 1'b1) begin fails++; $display("FAIL stream_gap cyc%0d: got %b want 1", i, valid_out); end
         end
      end
      valid_in = 1'b0;
      ok = got.size() == e.size();
      foreach (e[k]) if (k < got.size() && got[k] !== e[k]) ok = 0;
      checks++;
      if (!ok) begin fails++; $display("FAIL stream_bytes: got %p want %p", got, e); end
   endtask
   task automatic test_bypass();
      logic [7:0] e[$] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      bit ok;
      got.delete();
      for (int i = 0; i < 10; i++) begin
         valid_in = i == 0 || i == 4;
         data_in = i == 0 ? 32'h01020304 : 32'hDEADBEEF;
         tick();
         checks++;
         if (obs !== expv() || ready_out !== 1'b1) begin fails++; $display("FAIL bypass cyc%0d: got %h want %h (ready must stay 1)", i, obs, expv()); end
      end
      valid_in = 1'b0;
      ok = got.size() == e.size();
      foreach (e[k]) if (k < got.size() && got[k] !== e[k]) ok = 0;
      checks++;
      if (!ok) begin fails++; $display("FAIL bypass_bytes: got %p want %p", got, e); end
   endtask
   task automatic test_backpressure();
      logic [31:0] w[3] = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3};
      logic [7:0] e[$];
      int idx = 0;
      int lows = 0;
      bit ok;
      foreach (w[j]) for (int k = 3; k >= 0; k--) e.push_back(w[j][8*k +: 8]);
      got.delete();
      for (int i = 0; i < 16; i++) begin
         valid_in = idx < 3; data_in = w[idx % 3];
         tick();
         if (acc) idx++;
         if (!ready_out) lows++;
         checks++;
         if (obs !== expv()) begin fails++; $display("FAIL backpressure cyc%0d: got %h want %h", i, obs, expv()); end
      end
      valid_in = 1'b0;
      checks++;
      if (lows != 6) begin fails++; $display("FAIL bp_ready_low: got %0d want 6", lows); end
      ok = got.size() == e.size();
      foreach (e[k]) if (k < got.size() && got[k] !== e[k]) ok = 0;
      checks++;
      if (!ok) begin fails++; $display("FAIL bp_bytes: got %p want %p", got, e); end
   endtask
   task automatic test_mid_reset();
      valid_in = 1'b1; data_in = 32'hCAFEF00D;
      tick();
      valid_in = 1'b0;
      tick();
      checks++;
      if (obs !== expv() || data_out !== 8'hFE) begin fails++; $display("FAIL midreset_byte1: got %h want %h", obs, expv()); end
      reset_L = 1'b0;
      tick();
      checks++;
      if (obs !== 11'b0_00000000_1_1) begin fails++; $display("FAIL midreset_state: got %h want %h", obs, 11'b0_00000000_1_1); end
      reset_L = 1'b1;
      got.delete();
      for (int i = 0; i < 6; i++) tick();
      checks++;
      if (got.size() != 0) begin fails++; $display("FAIL midreset_leak: got %0d bytes want 0", got.size()); end
   endtask
   task automatic test_idle();
      reset_L = 1'b0;
      tick();
      reset_L = 1'b1; valid_in = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (obs !== 11'b0_00000000_1_1) begin fails++; $display("FAIL idle cyc%0d: got %h want %h", i, obs, 11'b0_00000000_1_1); end
      end
   endtask
   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         reset_L  = $urandom_range(0, 49) != 0;
         valid_in = $urandom_range(0, 2) != 0;
         data_in  = $urandom;
         tick();
         checks++;
         if (obs !== expv()) begin fails++; $display("FAIL random cyc%0d: got %h want %h", i, obs, expv()); end
      end
      reset_L = 1'b1; valid_in = 1'b0;
   endtask
   initial begin
      test_reset();
      test_single();
      test_stream();
      test_bypass();
      test_backpressure();
      test_mid_reset();
      test_idle();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
